dcache_direct_wb: RTL and testbench
===================================

Name: dcache_direct_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache between the single-cycle MIPS core's data port and a slow block-wide data memory.
- The core presents word requests. The cache answers hits combinationally in the same cycle. On a miss it asserts proc_stall while it writes back a dirty victim and refills the line through a req/ready handshake.
- 8 lines x 4 words x 32 bits.

Parameters:
- ADDR_W, 30, processor word-address width.
- INDEX_W, 3, line index width (2^INDEX_W lines). Tag width TAG_W = ADDR_W-INDEX_W-2.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- proc_read  input  1  processor load request
- proc_write  input  1  processor store request
- proc_addr  input  ADDR_W  word address; [1:0] word offset, [INDEX_W+1:2] index, upper bits tag
- proc_wdata  input  32  store data
- proc_rdata  output  32  load data, valid when proc_read=1 and proc_stall=0
- proc_stall  output  1  core must hold its request and freeze PC while 1
- mem_read  output  1  block refill request
- mem_write  output  1  block write-back request
- mem_addr  output  ADDR_W-2  block address {tag,index}
- mem_wdata  output  128  victim block, word0 in [31:0]
- mem_rdata  input  128  refill block, word0 in [31:0]
- mem_ready  input  1  one-cycle pulse: request complete / mem_rdata valid

Behaviour:
- Storage: per line valid, dirty, tag[TAG_W-1:0], data[127:0]. Reset clears all valid and dirty bits; data and tag arrays need no reset.
- Reset values: state=IDLE; mem_read=0, mem_write=0, proc_stall=0. mem_addr, mem_wdata and proc_rdata are don't-care.
- Request: req = proc_read|proc_write. If both are 1, treat as a write.
- Hit: req & valid[idx] & tag match. No req -> stall=0, no state change.
- FSM states: IDLE, WRITEBACK, ALLOCATE. Outputs decode from state plus live inputs.
- IDLE:
  - Read hit: proc_rdata = selected word (combinational), stall=0.
  - Write hit: stall=0; the selected word is written at the next edge and dirty=1; the other words are unchanged.
  - Miss on a clean or invalid line: stall=1, next state ALLOCATE.
  - Miss on a valid dirty line: stall=1, next state WRITEBACK.
- WRITEBACK:
  - stall=1, mem_write=1, mem_addr={stored tag,idx}, mem_wdata=line data, all held stable.
  - On mem_ready=1: next state ALLOCATE; clear dirty at that edge.
- ALLOCATE:
  - stall=1, mem_read=1, mem_addr={req tag,idx}, held stable.
  - On mem_ready=1: at that edge load data=mem_rdata, tag=req tag, valid=1, dirty=0; next state IDLE.
  - The following IDLE cycle resolves as a hit. For a store this is where the word merges and dirty is set.
- mem_read and mem_write are never both 1. Both drop in the cycle after mem_ready.
- mem_ready sampled in IDLE is ignored.
- Miss latency: miss detected in cycle 0; mem_ready first seen in cycle k.
  - Clean miss: stall=1 in cycles 0..k, stall=0 (hit) in cycle k+1.
  - Dirty miss: add the write-back handshake cycles.
- The core holds proc_addr/proc_wdata/proc_read/proc_write constant while stalled. The cache uses live inputs.
- Reset asserted mid-transaction: state=IDLE immediately; mem_read/mem_write drop asynchronously; all lines invalidated; the in-flight memory transfer is abandoned and its data lost.
- Index wrap: addresses differing only in tag map to the same line. Conflict eviction must follow dirty rules exactly.

Test Plan:
- Reset, then proc_read addr 0x0000_0004 → stall=1, next cycle mem_read=1 with mem_addr=0x0000_0001.
  - mem_ready in cycle 3 with mem_rdata={D,C,B,A} → stall=0 in cycle 4, proc_rdata=A.
  - Then read 0x0000_0007 → stall=0 same cycle, proc_rdata=D.
- Write hit: store 0xDEADBEEF to 0x0000_0005 after refill → stall=0.
  - Read 0x0000_0005 → 0xDEADBEEF; line dirty; no mem activity.
- Dirty conflict: after the write above, read 0x0000_0085 (same index 1, tag 4) → mem_write=1, mem_addr=0x0000_0001, mem_wdata word1=0xDEADBEEF.
  - After mem_ready → mem_read=1, mem_addr=0x0000_0021.
  - After the second mem_ready → hit returns refill word1.
- Write miss on an invalid line: store 0x12345678 to 0x0000_0010 → refill of block 0x0000_0004.
  - Then the word merges; a read returns 0x12345678 and other words equal the refill data.
- mem_ready held low 20 cycles in ALLOCATE → mem_read, mem_addr stable, stall=1 throughout; no extra requests.
- rst_n pulsed low during WRITEBACK → mem_write=0 immediately, stall=0.
  - After release, a read to a previously cached address misses (valid cleared).

Source files
------------

// File: rtl/dcache_direct_wb_if.sv
// Core data-port and block-memory signals seen by the direct-mapped write-back cache.
// master = core/memory environment, slave = cache.
interface dcache_direct_wb_if #(
    parameter int unsigned ADDR_W = 30
);
    logic              proc_read;
    logic              proc_write;
    logic [ADDR_W-1:0] proc_addr;
    logic [31:0]       proc_wdata;
    logic [31:0]       proc_rdata;
    logic              proc_stall;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-3:0] mem_addr;
    logic [127:0]      mem_wdata;
    logic [127:0]      mem_rdata;
    logic              mem_ready;

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_direct_wb.sv
// Direct-mapped write-back, write-allocate data cache: 2^INDEX_W lines of 4 x 32-bit words.
// Hits answer combinationally; misses stall the core through write-back and refill.
module dcache_direct_wb #(
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned INDEX_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    dcache_direct_wb_if.slave bus
);
    localparam int unsigned TAG_W = ADDR_W - INDEX_W - 2;
    localparam int unsigned LINES = 2 ** INDEX_W;

    typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

    state_e state_q, state_d;

    logic [LINES-1:0] valid_q, dirty_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [127:0]     data_q [LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         off;
    logic               req, hit;
    logic               write_hit, wb_done, fill_done;

    assign idx = bus.proc_addr[INDEX_W+1:2];
    assign tag = bus.proc_addr[ADDR_W-1:INDEX_W+2];
    assign off = bus.proc_addr[1:0];
    assign req = bus.proc_read | bus.proc_write;
    assign hit = req & valid_q[idx] & (tag_q[idx] == tag);

    always_comb begin
        state_d        = state_q;
        bus.proc_stall = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = {tag, idx};
        bus.mem_wdata  = data_q[idx];
        bus.proc_rdata = data_q[idx][{off, 5'd0} +: 32];
        write_hit      = 1'b0;
        wb_done        = 1'b0;
        fill_done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req && !hit) begin
                    bus.proc_stall = 1'b1;
                    state_d = (valid_q[idx] && dirty_q[idx]) ? StWriteback : StAllocate;
                end
                // A store with both strobes set is treated as a write.
                write_hit = hit & bus.proc_write;
            end
            StWriteback: begin
                bus.proc_stall = 1'b1;
                bus.mem_write  = 1'b1;
                bus.mem_addr   = {tag_q[idx], idx};
                if (bus.mem_ready) begin
                    wb_done = 1'b1;
                    state_d = StAllocate;
                end
            end
            StAllocate: begin
                bus.proc_stall = 1'b1;
                bus.mem_read   = 1'b1;
                if (bus.mem_ready) begin
                    fill_done = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (write_hit) dirty_q[idx] <= 1'b1;
            if (wb_done)   dirty_q[idx] <= 1'b0;
            if (fill_done) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end

    // Tag and data arrays are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (write_hit) data_q[idx][{off, 5'd0} +: 32] <= bus.proc_wdata;
        if (fill_done) begin
            data_q[idx] <= bus.mem_rdata;
            tag_q[idx]  <= tag;
        end
    end
endmodule

// File: tb/tb_dcache_direct_wb.sv
// Directed bench for dcache_direct_wb: refill, hits, dirty eviction, write miss,
// a slow memory and reset during write-back.
module tb_dcache_direct_wb;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    dcache_direct_wb_if #(.ADDR_W(30)) bus ();

    dcache_direct_wb #(.ADDR_W(30), .INDEX_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] d);
        bus.proc_read  = rd;
        bus.proc_write = wr;
        bus.proc_addr  = a;
        bus.proc_wdata = d;
    endtask

    localparam logic [127:0] BLK1 = {32'hD0D0_0004, 32'hC0C0_0003, 32'hB0B0_0002, 32'hA0A0_0001};
    localparam logic [127:0] BLK2 = {32'h2222_0004, 32'h2222_0003, 32'h2222_0002, 32'h2222_0001};
    localparam logic [127:0] BLK3 = {32'h3333_0004, 32'h3333_0003, 32'h3333_0002, 32'h3333_0001};
    localparam logic [127:0] JUNK = {4{32'hBAD0_BAD0}};

    initial begin
        rst_n         = 1'b0;
        req(1'b0, 1'b0, 30'h0, 32'h0);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        #12;
        chk("reset_stall", bus.proc_stall, 0);
        chk("reset_mem_read", bus.mem_read, 0);
        chk("reset_mem_write", bus.mem_write, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Clean miss on read of word 1, index 1
        req(1'b1, 1'b0, 30'h4, 32'h0);
        #1;
        chk("miss_c0_stall", bus.proc_stall, 1);
        chk("miss_c0_mem_read", bus.mem_read, 0);
        tick();
        chk("miss_c1_mem_read", bus.mem_read, 1);
        chk("miss_c1_mem_addr", bus.mem_addr, 28'h1);
        chk("miss_c1_stall", bus.proc_stall, 1);
        chk("miss_c1_mem_write", bus.mem_write, 0);
        tick();
        chk("miss_c2_mem_read", bus.mem_read, 1);
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = BLK1;
        #1;
        chk("miss_c3_stall", bus.proc_stall, 1);
        tick();
        bus.mem_ready = 1'b0;
        #1;
        chk("miss_c4_stall", bus.proc_stall, 0);
        chk("miss_c4_rdata", bus.proc_rdata, 32'hA0A0_0001);
        chk("miss_c4_mem_read", bus.mem_read, 0);

        req(1'b1, 1'b0, 30'h7, 32'h0);
        #1;
        chk("hit7_stall", bus.proc_stall, 0);
        chk("hit7_rdata", bus.proc_rdata, 32'hD0D0_0004);

        // Stray mem_ready while idle must not touch the line
        req(1'b0, 1'b0, 30'h4, 32'h0);
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = JUNK;
        tick();
        bus.mem_ready = 1'b0;
        req(1'b1, 1'b0, 30'h4, 32'h0);
        #1;
        chk("idle_ready_stall", bus.proc_stall, 0);
        chk("idle_ready_rdata", bus.proc_rdata, 32'hA0A0_0001);

        // Write hit
        tick();
        req(1'b0, 1'b1, 30'h5, 32'hDEAD_BEEF);
        #1;
        chk("whit_stall", bus.proc_stall, 0);
        tick();
        req(1'b1, 1'b0, 30'h5, 32'h0);
        #1;
        chk("whit_rdata", bus.proc_rdata, 32'hDEAD_BEEF);
        chk("whit_stall2", bus.proc_stall, 0);
        chk("whit_mem_idle", {bus.mem_read, bus.mem_write}, 2'b00);

        // Dirty conflict: tag 4, index 1
        tick();
        req(1'b1, 1'b0, 30'h85, 32'h0);
        #1;
        chk("dirty_c0_stall", bus.proc_stall, 1);
        tick();
        chk("wb_mem_write", bus.mem_write, 1);
        chk("wb_mem_read", bus.mem_read, 0);
        chk("wb_mem_addr", bus.mem_addr, 28'h1);
        chk("wb_word1", bus.mem_wdata[63:32], 32'hDEAD_BEEF);
        chk("wb_block", bus.mem_wdata,
            {32'hD0D0_0004, 32'hC0C0_0003, 32'hDEAD_BEEF, 32'hA0A0_0001});
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        #1;
        chk("alloc_mem_write", bus.mem_write, 0);
        chk("alloc_mem_read", bus.mem_read, 1);
        chk("alloc_mem_addr", bus.mem_addr, 28'h21);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = BLK2;
        tick();
        bus.mem_ready = 1'b0;
        #1;
        chk("conflict_stall", bus.proc_stall, 0);
        chk("conflict_rdata", bus.proc_rdata, 32'h2222_0002);

        // Write miss on invalid line 4 with a slow memory
        tick();
        req(1'b0, 1'b1, 30'h10, 32'h1234_5678);
        #1;
        chk("wmiss_stall", bus.proc_stall, 1);
        tick();
        chk("wmiss_mem_write", bus.mem_write, 0);
        for (int i = 0; i < 20; i++) begin
            chk("slow_mem_read", bus.mem_read, 1);
            chk("slow_mem_addr", bus.mem_addr, 28'h4);
            chk("slow_stall", bus.proc_stall, 1);
            chk("slow_mem_write", bus.mem_write, 0);
            tick();
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = BLK3;
        tick();
        bus.mem_ready = 1'b0;
        #1;
        chk("wmiss_hit_stall", bus.proc_stall, 0);
        chk("wmiss_hit_mem_read", bus.mem_read, 0);
        tick();
        req(1'b1, 1'b0, 30'h10, 32'h0);
        #1;
        chk("wmiss_merged", bus.proc_rdata, 32'h1234_5678);
        req(1'b1, 1'b0, 30'h11, 32'h0);
        #1;
        chk("wmiss_word1", bus.proc_rdata, 32'h3333_0002);
        req(1'b1, 1'b0, 30'h13, 32'h0);
        #1;
        chk("wmiss_word3", bus.proc_rdata, 32'h3333_0004);
        chk("wmiss_read_stall", bus.proc_stall, 0);

        // Reset during write-back of dirty line 4 (tag 4 evicts tag 0)
        tick();
        req(1'b1, 1'b0, 30'h90, 32'h0);
        tick();
        chk("rst_wb_mem_write", bus.mem_write, 1);
        chk("rst_wb_mem_addr", bus.mem_addr, 28'h4);
        #2;
        rst_n = 1'b0;
        req(1'b0, 1'b0, 30'h0, 32'h0);
        #1;
        chk("rst_mid_mem_write", bus.mem_write, 0);
        chk("rst_mid_stall", bus.proc_stall, 0);
        tick();
        rst_n = 1'b1;
        tick();
        req(1'b1, 1'b0, 30'h4, 32'h0);
        #1;
        chk("post_rst_miss", bus.proc_stall, 1);
        tick();
        chk("post_rst_mem_read", bus.mem_read, 1);
        chk("post_rst_mem_write", bus.mem_write, 0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = BLK1;
        tick();
        bus.mem_ready = 1'b0;
        #1;
        chk("post_rst_refill", bus.proc_rdata, 32'hA0A0_0001);
        req(1'b0, 1'b0, 30'h0, 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
